// File: rtl/rmst_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | rmst_arb_pkg : shared types and helpers for rmst_read_arbiter             |
// | Rev 1.0 : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package rmst_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int unsigned XDW_BYTES = 16;

  // Ceiling division of a byte length by the beat size.
  function automatic logic [63:0] beat_count(input logic [63:0] len_bytes,
                                             input int unsigned bytes_per_beat);
    logic [63:0] b;
    b = 64'(bytes_per_beat);
    return (len_bytes + b - 64'd1) / b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational one-hot round-robin picker starting at ptr     |
// | Rev 1.0 : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'((int'(ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rmst_read_arbiter.sv
// +----------------------------------------------------------------------------+
// | rmst_read_arbiter : shares one Avalon read master among NREQ load clients |
// | Optional: RMST_ARB_PERF_EN adds per-client busy-cycle counters            |
// | Rev 1.0 : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module rmst_read_arbiter
  import rmst_arb_pkg::*;
#(
  parameter int XAW  = 32,
  parameter int XDW  = int'(8 * XDW_BYTES),
  parameter int NREQ = 2,
  parameter int CW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     cli_go,
  input  logic [NREQ*XAW-1:0] cli_read_base,
  input  logic [NREQ*XAW-1:0] cli_read_length,
  input  logic [NREQ-1:0]     cli_fixed_location,
  output logic [NREQ-1:0]     cli_done,
  input  logic [NREQ-1:0]     cli_user_read_buffer,
  output logic [NREQ-1:0]     cli_user_data_available,
  output logic [XDW-1:0]      cli_user_buffer_data,
  output logic                rmst_fixed_location,
  output logic [XAW-1:0]      rmst_read_base,
  output logic [XAW-1:0]      rmst_read_length,
  output logic                rmst_go,
  input  logic                rmst_done,
  output logic                rmst_user_read_buffer,
  input  logic [XDW-1:0]      rmst_user_buffer_data,
  input  logic                rmst_user_data_available,
  output logic [NREQ-1:0]     grant,
  output logic                err_go_busy
`ifdef RMST_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]  perf_busy_cycles
`endif
);

  localparam int          PW           = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned C_BEAT_BYTES = XDW / 8;

  state_t          r_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;
  logic [NREQ-1:0] r_pending;
  logic [NREQ-1:0] r_fixed;
  logic [XAW-1:0]  r_base [NREQ];
  logic [XAW-1:0]  r_len  [NREQ];
  logic            r_zero_valid;
  logic [CW-1:0]   r_beats;
  logic [CW-1:0]   r_cnt;
  logic            r_done_q;

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_sel_idx;
  logic [CW-1:0]   w_sel_beats;
  logic            w_sel_zero;
  logic            w_select;
  logic [NREQ-1:0] w_accept;
  logic [NREQ-1:0] w_reject;
  logic [NREQ-1:0] w_owner_oh;
  logic [NREQ-1:0] w_clear;
  logic            w_data_phase;
  logic            w_pop;
  logic            w_drain_done;
  logic            w_zero_done;
  logic            w_complete;
  logic [PW-1:0]   w_next_ptr;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req (r_pending),
    .ptr (r_rr_ptr),
    .gnt (w_gnt)
  );

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_sel_idx = PW'(i);
    end
  end

  assign w_sel_beats  = CW'(beat_count(64'(r_len[w_sel_idx]), C_BEAT_BYTES));
  assign w_sel_zero   = (r_len[w_sel_idx] == '0);
  // A pending zero-length completion blocks new selection for one cycle.
  assign w_select     = (r_state == S_IDLE) && !r_zero_valid && (|r_pending) && rmst_done;

  assign w_accept     = cli_go & ~r_pending;
  assign w_reject     = cli_go &  r_pending;
  assign cli_done     = ~r_pending;

  assign w_data_phase = (r_state == S_BUSY) || (r_state == S_DRAIN);
  assign w_pop        = w_data_phase && cli_user_read_buffer[r_owner];
  assign w_drain_done = (r_state == S_DRAIN) && (r_cnt == r_beats);
  assign w_zero_done  = (r_state == S_IDLE) && r_zero_valid;
  assign w_complete   = w_drain_done || w_zero_done;
  assign w_clear      = w_complete ? w_owner_oh : '0;
  assign w_next_ptr   = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);

  assign rmst_go               = (r_state == S_ISSUE);
  assign rmst_user_read_buffer = w_pop;
  assign cli_user_buffer_data  = rmst_user_buffer_data;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_client
    assign w_owner_oh[gi]              = (r_owner == PW'(gi));
    assign grant[gi]                   = (r_state != S_IDLE) && w_owner_oh[gi];
    assign cli_user_data_available[gi] = rmst_user_data_available && w_owner_oh[gi] && w_data_phase;
  end

  // Per-client request registers; a go is only accepted while cli_done is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending   <= '0;
      r_fixed     <= '0;
      err_go_busy <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        r_base[i] <= '0;
        r_len[i]  <= '0;
      end
    end else begin
      r_pending <= (r_pending | w_accept) & ~w_clear;
      for (int i = 0; i < NREQ; i++) begin
        if (w_accept[i]) begin
          r_base[i]  <= cli_read_base[i*XAW +: XAW];
          r_len[i]   <= cli_read_length[i*XAW +: XAW];
          r_fixed[i] <= cli_fixed_location[i];
        end
      end
      if (|w_reject) err_go_busy <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state             <= S_IDLE;
      r_owner             <= '0;
      r_rr_ptr            <= '0;
      r_zero_valid        <= 1'b0;
      r_beats             <= '0;
      r_cnt               <= '0;
      r_done_q            <= 1'b1;
      rmst_read_base      <= '0;
      rmst_read_length    <= '0;
      rmst_fixed_location <= 1'b0;
    end else begin
      r_done_q <= rmst_done;
      if (w_pop) r_cnt <= r_cnt + CW'(1);
      if (w_complete) begin
        r_rr_ptr     <= w_next_ptr;
        r_zero_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_select) begin
            r_owner <= w_sel_idx;
            if (w_sel_zero) begin
              r_zero_valid <= 1'b1;
            end else begin
              r_state             <= S_ISSUE;
              r_beats             <= w_sel_beats;
              r_cnt               <= '0;
              rmst_read_base      <= r_base[w_sel_idx];
              rmst_read_length    <= r_len[w_sel_idx];
              rmst_fixed_location <= r_fixed[w_sel_idx];
            end
          end
        end
        S_ISSUE: r_state <= S_BUSY;
        // The master signals burst end by a rising edge of rmst_done.
        S_BUSY:  if (rmst_done && !r_done_q) r_state <= S_DRAIN;
        S_DRAIN: if (w_drain_done) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RMST_ARB_PERF_EN
  for (genvar gp = 0; gp < NREQ; gp++) begin : g_perf
    logic [31:0] r_busy_cnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_busy_cnt <= '0;
      end else if (grant[gp] && (r_busy_cnt != 32'hFFFF_FFFF)) begin
        r_busy_cnt <= r_busy_cnt + 32'd1;
      end
    end
    assign perf_busy_cycles[gp*32 +: 32] = r_busy_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rmst_read_arbiter.sv
// Directed self-checking bench for rmst_read_arbiter (XDW=128, NREQ=2).
`timescale 1ns/1ps
`default_nettype none

module tb_rmst_read_arbiter;

  localparam int XAW  = 32;
  localparam int XDW  = 128;
  localparam int NREQ = 2;
  localparam int CW   = 16;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     cli_go;
  logic [NREQ*XAW-1:0] cli_read_base;
  logic [NREQ*XAW-1:0] cli_read_length;
  logic [NREQ-1:0]     cli_fixed_location;
  logic [NREQ-1:0]     cli_done;
  logic [NREQ-1:0]     cli_user_read_buffer;
  logic [NREQ-1:0]     cli_user_data_available;
  logic [XDW-1:0]      cli_user_buffer_data;
  logic                rmst_fixed_location;
  logic [XAW-1:0]      rmst_read_base;
  logic [XAW-1:0]      rmst_read_length;
  logic                rmst_go;
  logic                rmst_done;
  logic                rmst_user_read_buffer;
  logic [XDW-1:0]      rmst_user_buffer_data;
  logic                rmst_user_data_available;
  logic [NREQ-1:0]     grant;
  logic                err_go_busy;
`ifdef RMST_ARB_PERF_EN
  logic [NREQ*32-1:0]  perf_busy_cycles;
`endif

  int checks;
  int errors;

  rmst_read_arbiter #(.XAW(XAW), .XDW(XDW), .NREQ(NREQ), .CW(CW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .cli_go                   (cli_go),
    .cli_read_base            (cli_read_base),
    .cli_read_length          (cli_read_length),
    .cli_fixed_location       (cli_fixed_location),
    .cli_done                 (cli_done),
    .cli_user_read_buffer     (cli_user_read_buffer),
    .cli_user_data_available  (cli_user_data_available),
    .cli_user_buffer_data     (cli_user_buffer_data),
    .rmst_fixed_location      (rmst_fixed_location),
    .rmst_read_base           (rmst_read_base),
    .rmst_read_length         (rmst_read_length),
    .rmst_go                  (rmst_go),
    .rmst_done                (rmst_done),
    .rmst_user_read_buffer    (rmst_user_read_buffer),
    .rmst_user_buffer_data    (rmst_user_buffer_data),
    .rmst_user_data_available (rmst_user_data_available),
    .grant                    (grant),
    .err_go_busy              (err_go_busy)
`ifdef RMST_ARB_PERF_EN
    ,
    .perf_busy_cycles         (perf_busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [31:0] base, input logic [31:0] len,
                           input logic fixed);
    cli_read_base[i*XAW +: XAW]   = base;
    cli_read_length[i*XAW +: XAW] = len;
    cli_fixed_location[i]         = fixed;
  endtask

  task automatic pop_n(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      rmst_user_data_available = 1'b1;
      cli_user_read_buffer[i]  = 1'b1;
      cyc();
    end
    cli_user_read_buffer     = '0;
    rmst_user_data_available = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc();
    cli_user_read_buffer = 2'b11; rmst_user_data_available = 1'b1; #1;
    checks++; if (rmst_go !== 1'b0) begin errors++; $display("FAIL reset_rmst_go: got %b want 0", rmst_go); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (rmst_read_base !== 32'h0 || rmst_read_length !== 32'h0 || rmst_fixed_location !== 1'b0) begin
      errors++; $display("FAIL reset_params: got base %h len %h fixed %b want 0", rmst_read_base, rmst_read_length, rmst_fixed_location); end
    checks++; if (rmst_user_read_buffer !== 1'b0 || cli_user_data_available !== 2'b00) begin
      errors++; $display("FAIL reset_routing: got pop %b avail %b want 0/00", rmst_user_read_buffer, cli_user_data_available); end
    checks++; if (err_go_busy !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_go_busy); end
    checks++; if (cli_done !== 2'b11) begin errors++; $display("FAIL reset_cli_done: got %b want 11", cli_done); end
    cli_user_read_buffer = '0; rmst_user_data_available = 1'b0;
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    drive_req(0, 32'h0000_1000, 32'd128, 1'b0);
    cli_go = 2'b01; cyc(); cli_go = 2'b00;
    checks++; if (cli_done !== 2'b10) begin errors++; $display("FAIL single_done_drop: got %b want 10", cli_done); end
    checks++; if (rmst_go !== 1'b0) begin errors++; $display("FAIL single_go_early: got %b want 0", rmst_go); end
    cyc();
    checks++; if (rmst_go !== 1'b1) begin errors++; $display("FAIL single_go: got %b want 1", rmst_go); end
    checks++; if (rmst_read_base !== 32'h0000_1000 || rmst_read_length !== 32'd128) begin
      errors++; $display("FAIL single_params: got base %h len %0d want 1000/128", rmst_read_base, rmst_read_length); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
    cyc();
    checks++; if (rmst_go !== 1'b0) begin errors++; $display("FAIL single_go_pulse: got %b want 0", rmst_go); end
    rmst_done = 1'b0;
    rmst_user_buffer_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    rmst_user_data_available = 1'b1; cli_user_read_buffer = 2'b01; #1;
    checks++; if (rmst_user_read_buffer !== 1'b1 || cli_user_data_available !== 2'b01) begin
      errors++; $display("FAIL single_route: got pop %b avail %b want 1/01", rmst_user_read_buffer, cli_user_data_available); end
    checks++; if (cli_user_buffer_data !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA) begin
      errors++; $display("FAIL single_data: got %h", cli_user_buffer_data); end
    cyc();
    pop_n(0, 7);
    rmst_done = 1'b1; cyc();
    checks++; if (cli_done !== 2'b10 || grant !== 2'b01) begin
      errors++; $display("FAIL single_drain: got done %b grant %b want 10/01", cli_done, grant); end
    cyc();
    checks++; if (cli_done !== 2'b11 || grant !== 2'b00) begin
      errors++; $display("FAIL single_complete: got done %b grant %b want 11/00", cli_done, grant); end
  endtask

  task automatic test_round_robin();
    rst = 1'b0; cyc(); rst = 1'b1; cyc();
    drive_req(0, 32'h0000_2000, 32'd32, 1'b0);
    drive_req(1, 32'h0000_3000, 32'd48, 1'b1);
    cli_go = 2'b11; cyc(); cli_go = 2'b00;
    checks++; if (cli_done !== 2'b00) begin errors++; $display("FAIL rr_both_latched: got %b want 00", cli_done); end
    cyc();
    checks++; if (rmst_go !== 1'b1 || grant !== 2'b01 || rmst_read_base !== 32'h0000_2000) begin
      errors++; $display("FAIL rr_first: got go %b grant %b base %h want 1/01/2000", rmst_go, grant, rmst_read_base); end
    cyc(); rmst_done = 1'b0;
    rmst_user_data_available = 1'b1; cli_user_read_buffer = 2'b10; #1;
    checks++; if (rmst_user_read_buffer !== 1'b0) begin errors++; $display("FAIL rr_nonowner_pop: got %b want 0", rmst_user_read_buffer); end
    checks++; if (cli_user_data_available !== 2'b01) begin errors++; $display("FAIL rr_nonowner_avail: got %b want 01", cli_user_data_available); end
    cyc();
    cli_user_read_buffer = '0; rmst_user_data_available = 1'b0;
    pop_n(0, 2);
    rmst_done = 1'b1; cyc(); cyc();
    checks++; if (cli_done !== 2'b01) begin errors++; $display("FAIL rr_first_done: got %b want 01", cli_done); end
    cyc();
    checks++; if (rmst_go !== 1'b1 || grant !== 2'b10) begin
      errors++; $display("FAIL rr_second: got go %b grant %b want 1/10", rmst_go, grant); end
    checks++; if (rmst_read_base !== 32'h0000_3000 || rmst_read_length !== 32'd48 || rmst_fixed_location !== 1'b1) begin
      errors++; $display("FAIL rr_second_params: got base %h len %0d fixed %b want 3000/48/1", rmst_read_base, rmst_read_length, rmst_fixed_location); end
    cyc(); rmst_done = 1'b0;
    rmst_user_data_available = 1'b1; cli_user_read_buffer = 2'b10; #1;
    checks++; if (cli_user_data_available !== 2'b10 || rmst_user_read_buffer !== 1'b1) begin
      errors++; $display("FAIL rr_second_route: got avail %b pop %b want 10/1", cli_user_data_available, rmst_user_read_buffer); end
    cyc();
    pop_n(1, 2);
    rmst_done = 1'b1; cyc(); cyc();
    checks++; if (cli_done !== 2'b11 || grant !== 2'b00) begin
      errors++; $display("FAIL rr_all_done: got done %b grant %b want 11/00", cli_done, grant); end
  endtask

  task automatic test_zero_length();
    logic go_seen;
    go_seen = 1'b0;
    drive_req(0, 32'h0000_6000, 32'd0, 1'b0);
    drive_req(1, 32'h0000_7000, 32'd0, 1'b0);
    cli_go = 2'b11; cyc(); cli_go = 2'b00;
    checks++; if (cli_done !== 2'b00) begin errors++; $display("FAIL zero_latched: got %b want 00", cli_done); end
    cyc(); go_seen |= rmst_go;
    cyc(); go_seen |= rmst_go;
    checks++; if (cli_done !== 2'b01) begin errors++; $display("FAIL zero_first_done: got %b want 01", cli_done); end
    cyc(); go_seen |= rmst_go;
    cyc(); go_seen |= rmst_go;
    checks++; if (cli_done !== 2'b11) begin errors++; $display("FAIL zero_second_done: got %b want 11", cli_done); end
    checks++; if (go_seen !== 1'b0) begin errors++; $display("FAIL zero_no_go: got %b want 0", go_seen); end
  endtask

  task automatic test_drain_pending();
    drive_req(0, 32'h0000_4000, 32'd120, 1'b1);
    cli_go = 2'b01; cyc(); cli_go = 2'b00; cyc();
    checks++; if (rmst_go !== 1'b1 || rmst_fixed_location !== 1'b1 || rmst_read_length !== 32'd120) begin
      errors++; $display("FAIL drain_issue: got go %b fixed %b len %0d want 1/1/120", rmst_go, rmst_fixed_location, rmst_read_length); end
    cyc(); rmst_done = 1'b0;
    pop_n(0, 5);
    rmst_done = 1'b1; cyc();
    checks++; if (cli_done !== 2'b10) begin errors++; $display("FAIL drain_enter: got %b want 10", cli_done); end
    cyc();
    checks++; if (cli_done !== 2'b10 || grant !== 2'b01) begin
      errors++; $display("FAIL drain_hold: got done %b grant %b want 10/01", cli_done, grant); end
    pop_n(0, 3);
    checks++; if (cli_done !== 2'b10) begin errors++; $display("FAIL drain_last_pop: got %b want 10", cli_done); end
    cyc();
    checks++; if (cli_done !== 2'b11) begin errors++; $display("FAIL drain_complete: got %b want 11", cli_done); end
  endtask

  task automatic test_busy_go_and_reset();
    drive_req(0, 32'h0000_8000, 32'd64, 1'b0);
    cli_go = 2'b01; cyc();
    drive_req(0, 32'h0000_9000, 32'd16, 1'b0);
    cyc(); cli_go = 2'b00;
    checks++; if (err_go_busy !== 1'b1) begin errors++; $display("FAIL busy_err: got %b want 1", err_go_busy); end
    checks++; if (rmst_go !== 1'b1 || rmst_read_base !== 32'h0000_8000 || rmst_read_length !== 32'd64) begin
      errors++; $display("FAIL busy_params: got go %b base %h len %0d want 1/8000/64", rmst_go, rmst_read_base, rmst_read_length); end
    cyc(); rmst_done = 1'b0;
    pop_n(0, 2);
    rmst_user_data_available = 1'b1; cli_user_read_buffer = 2'b01;
    rst = 1'b0; #1;
    checks++; if (grant !== 2'b00 || cli_done !== 2'b11 || err_go_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got grant %b done %b err %b want 00/11/0", grant, cli_done, err_go_busy); end
    checks++; if (rmst_user_read_buffer !== 1'b0 || cli_user_data_available !== 2'b00 || rmst_go !== 1'b0) begin
      errors++; $display("FAIL rst_mid_route: got pop %b avail %b go %b want 0/00/0", rmst_user_read_buffer, cli_user_data_available, rmst_go); end
    checks++; if (rmst_read_base !== 32'h0 || rmst_read_length !== 32'h0) begin
      errors++; $display("FAIL rst_mid_params: got base %h len %h want 0", rmst_read_base, rmst_read_length); end
    cli_user_read_buffer = '0; rmst_user_data_available = 1'b0; rmst_done = 1'b1;
    cyc(); rst = 1'b1; cyc();
    drive_req(1, 32'h0000_5000, 32'd16, 1'b0);
    cli_go = 2'b10; cyc(); cli_go = 2'b00;
    checks++; if (cli_done !== 2'b01) begin errors++; $display("FAIL post_rst_accept: got %b want 01", cli_done); end
    cyc();
    checks++; if (rmst_go !== 1'b1 || grant !== 2'b10 || rmst_read_base !== 32'h0000_5000) begin
      errors++; $display("FAIL post_rst_issue: got go %b grant %b base %h want 1/10/5000", rmst_go, grant, rmst_read_base); end
    cyc(); rmst_done = 1'b0;
    pop_n(1, 1);
    rmst_done = 1'b1; cyc(); cyc();
    checks++; if (cli_done !== 2'b11) begin errors++; $display("FAIL post_rst_complete: got %b want 11", cli_done); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    cli_go = '0;
    cli_read_base = '0;
    cli_read_length = '0;
    cli_fixed_location = '0;
    cli_user_read_buffer = '0;
    rmst_done = 1'b1;
    rmst_user_buffer_data = '0;
    rmst_user_data_available = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_zero_length();
    test_drain_pending();
    test_busy_go_and_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
